// File: rtl/lif_array.sv
// Time-multiplexed leaky integrate-and-fire neuron array.
// One shared update datapath; per-neuron potential and refractory storage.
module lif_array #(
  parameter int WIDTH     = 8,
  parameter int N_NEURONS = 4,
  parameter int REFR_W    = 4,
  localparam int IDW      = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDW-1:0]    in_id,
  input  logic [WIDTH-1:0]  in_current,
  input  logic [WIDTH-1:0]  cfg_threshold,
  input  logic [1:0]        cfg_decay,
  input  logic              cfg_reset_sub,
  input  logic [REFR_W-1:0] cfg_refractory,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDW-1:0]    out_id,
  output logic              out_spike,
  output logic [WIDTH-1:0]  out_state
);

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic             spike;
    logic [WIDTH-1:0] state;
  } out_t;

  logic [WIDTH-1:0]  state_q [N_NEURONS];
  logic [WIDTH-1:0]  state_d [N_NEURONS];
  logic [REFR_W-1:0] refr_q  [N_NEURONS];
  logic [REFR_W-1:0] refr_d  [N_NEURONS];

  logic out_valid_q;
  logic out_valid_d;
  out_t out_q;
  out_t out_d;

  logic              accept;
  logic              id_ok;
  logic [WIDTH-1:0]  cur_u;
  logic [REFR_W-1:0] cur_refr;
  logic              in_refr;
  logic [WIDTH-1:0]  dec_u;
  logic [WIDTH-1:0]  ieff;
  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  u_sat;
  logic [WIDTH-1:0]  sub_u;
  logic              spike;
  logic [WIDTH-1:0]  new_u;
  logic [REFR_W-1:0] new_refr;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Loop-based read mux: IDs past N_NEURONS simply miss every entry.
  always_comb begin
    id_ok    = 1'b0;
    cur_u    = '0;
    cur_refr = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (in_id == IDW'(i)) begin
        id_ok    = 1'b1;
        cur_u    = state_q[i];
        cur_refr = refr_q[i];
      end
    end
  end

  always_comb begin
    unique case (cfg_decay)
      2'd0:    dec_u = cur_u >> 1;
      2'd1:    dec_u = (cur_u >> 1) + (cur_u >> 2);
      2'd2:    dec_u = (cur_u >> 1) + (cur_u >> 2) + (cur_u >> 3);
      default: dec_u = cur_u;
    endcase
  end

  always_comb begin
    in_refr = (cur_refr != '0);
    ieff    = in_refr ? '0 : in_current;
    sum     = {1'b0, dec_u} + {1'b0, ieff};
    u_sat   = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    // Fire decision looks at the potential before this update.
    spike   = !in_refr && (cur_u >= cfg_threshold);
    sub_u   = (u_sat >= cfg_threshold) ? (u_sat - cfg_threshold) : '0;
    new_u   = u_sat;
    new_refr = cur_refr;
    if (spike) begin
      new_u    = cfg_reset_sub ? sub_u : '0;
      new_refr = cfg_refractory;
    end else if (in_refr) begin
      new_refr = cur_refr - REFR_W'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < N_NEURONS; i++) begin
      state_d[i] = state_q[i];
      refr_d[i]  = refr_q[i];
      if (accept && (in_id == IDW'(i))) begin
        state_d[i] = new_u;
        refr_d[i]  = new_refr;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_d.id    = in_id;
      out_d.spike = id_ok && spike;
      out_d.state = id_ok ? new_u : '0;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        state_q[i] <= '0;
        refr_q[i]  <= '0;
      end
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      for (int i = 0; i < N_NEURONS; i++) begin
        state_q[i] <= state_d[i];
        refr_q[i]  <= refr_d[i];
      end
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_q.id;
  assign out_spike = out_q.spike;
  assign out_state = out_q.state;

endmodule
